// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_mp register file.
// Optional build macro used by the register file: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned ZERO_REG  = 0;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned DEF_NREAD = 2;

    // An address names a real, writable register: not the zero register and inside the array.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
        return (addr != ZERO_REG) && (addr < depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Issue sets a bit, writeback clears it; a same-edge set wins because a newer
// producer has been issued. Bit 0 and out-of-range addresses never match.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic             clr_en_i,
    input  logic [AW-1:0]    clr_addr_i,
    output logic [DEPTH-1:0] busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: clear on writeback first, then let issue override it.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (clr_en_i && (clr_addr_i == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_en_i && (set_addr_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // Busy bit register, cleared immediately by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with integrated pending-write scoreboard.
// Register 0 reads as zero. Build macro REGFILE_BYPASS_EN enables same-edge
// write-to-read forwarding; without it a colliding read returns the old value
// and the pre-edge busy bit, so the consumer re-reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    parameter  int unsigned NREAD = DEF_NREAD,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_valid,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   sb_set_en,
    input  logic [AW-1:0]          sb_set_addr,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;
    logic [DEPTH-1:0] busy_w;

    assign wr_ok = wr_en && addr_valid(32'(wr_addr), DEPTH);

    // Register array: whole-array clear on reset, one write per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (sb_set_en),
        .set_addr_i (sb_set_addr),
        .clr_en_i   (wr_ok),
        .clr_addr_i (wr_addr),
        .busy_o     (busy_w)
    );

    assign busy_vec = busy_w;

    for (genvar gi = 0; gi < int'(NREAD); gi++) begin : g_rd
        logic [AW-1:0]    addr_w;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic             busy_d;
        logic             busy_q;
        logic             valid_q;

        assign addr_w = rd_addr[gi*AW +: AW];

        // Read value for this port: zero for invalid addresses, else array (or forwarded write).
        always_comb begin
            data_d = '0;
            busy_d = 1'b0;
            if (addr_valid(32'(addr_w), DEPTH)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_addr == addr_w)) begin
                    data_d = wr_data;
                    busy_d = sb_set_en && (sb_set_addr == addr_w);
                end else begin
                    data_d = mem_q[addr_w];
                    busy_d = busy_w[addr_w];
                end
`else
                data_d = mem_q[addr_w];
                busy_d = busy_w[addr_w];
`endif
            end
        end

        // Output registers: valid pulses per request, data and busy hold when idle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q  <= '0;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_en[gi];
                if (rd_en[gi]) begin
                    data_q <= data_d;
                    busy_q <= busy_d;
                end
            end
        end

        assign rd_data[gi*WIDTH +: WIDTH] = data_q;
        assign rd_valid[gi]               = valid_q;
        assign rd_busy[gi]                = busy_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (DEPTH=20 to exercise a non-power-of-two array).
// Honours REGFILE_BYPASS_EN for the collision expectations.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 20;
    localparam int NREAD = 2;
    localparam int AW    = $clog2(DEPTH);

    logic                   clk;
    logic                   rst;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_valid;
    logic [NREAD-1:0]       rd_busy;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   sb_set_en;
    logic [AW-1:0]          sb_set_addr;
    logic [DEPTH-1:0]       busy_vec;

    int compared;
    int mismatched;

    regfile_mp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NREAD (NREAD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en       = '0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    task automatic test_reset();
        // write reg5 and mark it pending on the same edge (set wins)
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_set_addr = 5;
        tick();
        idle();
        compared++;
        if (busy_vec[5] !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pre_busy5: got %b want 1", busy_vec[5]);
        end
        rd_en = 2'b01; rd_addr[0 +: AW] = 5;
        tick();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'hDEADBEEF || rd_busy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pre_read5: data %h busy %b want deadbeef 1", rd_data[0 +: WIDTH], rd_busy[0]);
        end
        // asynchronous reset mid-cycle, read request still asserted
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (rd_data !== '0 || rd_valid !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
            mismatched++;
            $display("FAIL rst_async: data %h valid %b busy %b vec %h want all 0", rd_data, rd_valid, rd_busy, busy_vec);
        end
        #1;
        rst = 1'b1;
        tick();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'h0 || rd_valid[0] !== 1'b1 || rd_busy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_post_read5: data %h valid %b busy %b want 0 1 0", rd_data[0 +: WIDTH], rd_valid[0], rd_busy[0]);
        end
        idle();
    endtask

    task automatic test_basic();
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h12345678;
        tick();
        idle();
        rd_en = 2'b11; rd_addr[0 +: AW] = 3; rd_addr[AW +: AW] = 3;
        tick();
        idle();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'h12345678 || rd_data[WIDTH +: WIDTH] !== 32'h12345678 || rd_valid !== 2'b11) begin
            mismatched++;
            $display("FAIL basic_read3: p0 %h p1 %h valid %b want 12345678 12345678 11",
                     rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH], rd_valid);
        end
        tick();
        compared++;
        if (rd_valid !== 2'b00 || rd_data[0 +: WIDTH] !== 32'h12345678) begin
            mismatched++;
            $display("FAIL basic_idle: valid %b p0 %h want 00 12345678 (held)", rd_valid, rd_data[0 +: WIDTH]);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        sb_set_en = 1'b1; sb_set_addr = 0;
        tick();
        idle();
        compared++;
        if (busy_vec[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_busy_vec0: got %b want 0", busy_vec[0]);
        end
        rd_en = 2'b11; rd_addr[0 +: AW] = 0; rd_addr[AW +: AW] = 0;
        tick();
        idle();
        compared++;
        if (rd_data !== '0 || rd_busy !== 2'b00 || rd_valid !== 2'b11) begin
            mismatched++;
            $display("FAIL zero_read0: data %h busy %b valid %b want 0 00 11", rd_data, rd_busy, rd_valid);
        end
    endtask

    task automatic test_collision();
        logic [WIDTH-1:0] exp_data;
        logic             exp_busy;
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h00000001;
        sb_set_en = 1'b1; sb_set_addr = 7;
        tick();
        idle();
        compared++;
        if (busy_vec[7] !== 1'b1) begin
            mismatched++;
            $display("FAIL coll_busy7_set: got %b want 1", busy_vec[7]);
        end
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
        rd_en = 2'b01; rd_addr[0 +: AW] = 7;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        exp_data = 32'hA5A5A5A5;
        exp_busy = 1'b0;
`else
        exp_data = 32'h00000001;
        exp_busy = 1'b1;
`endif
        compared++;
        if (rd_data[0 +: WIDTH] !== exp_data || rd_busy[0] !== exp_busy) begin
            mismatched++;
            $display("FAIL coll_read7: data %h busy %b want %h %b", rd_data[0 +: WIDTH], rd_busy[0], exp_data, exp_busy);
        end
        compared++;
        if (busy_vec[7] !== 1'b0) begin
            mismatched++;
            $display("FAIL coll_busy7_clr: got %b want 0", busy_vec[7]);
        end
        rd_en = 2'b10; rd_addr[AW +: AW] = 7;
        tick();
        idle();
        compared++;
        if (rd_data[WIDTH +: WIDTH] !== 32'hA5A5A5A5 || rd_busy[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL coll_reread7: data %h busy %b want a5a5a5a5 0", rd_data[WIDTH +: WIDTH], rd_busy[1]);
        end
    endtask

    task automatic test_scoreboard();
        sb_set_en = 1'b1; sb_set_addr = 9;
        tick();
        idle();
        compared++;
        if (busy_vec !== 20'h00200) begin
            mismatched++;
            $display("FAIL sb_set9: vec %h want 00200", busy_vec);
        end
        rd_en = 2'b01; rd_addr[0 +: AW] = 9;
        tick();
        idle();
        compared++;
        if (rd_busy[0] !== 1'b1 || rd_valid[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL sb_read9_busy: busy %b valid %b want 1 1", rd_busy[0], rd_valid[0]);
        end
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h00000099;
        sb_set_en = 1'b1; sb_set_addr = 9;
        tick();
        idle();
        compared++;
        if (busy_vec[9] !== 1'b1) begin
            mismatched++;
            $display("FAIL sb_set_wins: got %b want 1", busy_vec[9]);
        end
        // idle port keeps its previous busy flag
        compared++;
        if (rd_busy[0] !== 1'b1 || rd_valid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL sb_hold_busy: busy %b valid %b want 1 0", rd_busy[0], rd_valid[0]);
        end
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h0000009A;
        tick();
        idle();
        compared++;
        if (busy_vec[9] !== 1'b0) begin
            mismatched++;
            $display("FAIL sb_clear9: got %b want 0", busy_vec[9]);
        end
        rd_en = 2'b01; rd_addr[0 +: AW] = 9;
        tick();
        idle();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'h0000009A || rd_busy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL sb_read9_after: data %h busy %b want 0000009a 0", rd_data[0 +: WIDTH], rd_busy[0]);
        end
    endtask

    task automatic test_out_of_range();
        wr_en = 1'b1; wr_addr = 25; wr_data = 32'hCAFEF00D;
        sb_set_en = 1'b1; sb_set_addr = 25;
        rd_en = 2'b10; rd_addr[AW +: AW] = 25;
        tick();
        idle();
        compared++;
        if (busy_vec !== '0) begin
            mismatched++;
            $display("FAIL oor_busy_vec: vec %h want 00000", busy_vec);
        end
        compared++;
        if (rd_data[WIDTH +: WIDTH] !== 32'h0 || rd_busy[1] !== 1'b0 || rd_valid[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_same_edge_read: data %h busy %b valid %b want 0 0 1",
                     rd_data[WIDTH +: WIDTH], rd_busy[1], rd_valid[1]);
        end
        rd_en = 2'b11; rd_addr[0 +: AW] = 3; rd_addr[AW +: AW] = 25;
        tick();
        idle();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'h12345678 || rd_data[WIDTH +: WIDTH] !== 32'h0 || rd_busy !== 2'b00) begin
            mismatched++;
            $display("FAIL oor_read25: p0 %h p1 %h busy %b want 12345678 0 00",
                     rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH], rd_busy);
        end
    endtask

    task automatic test_back_to_back();
        rd_en = 2'b11; rd_addr[0 +: AW] = 3; rd_addr[AW +: AW] = 7;
        tick();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'h12345678 || rd_data[WIDTH +: WIDTH] !== 32'hA5A5A5A5) begin
            mismatched++;
            $display("FAIL b2b_first: p0 %h p1 %h want 12345678 a5a5a5a5", rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH]);
        end
        rd_addr[0 +: AW] = 7; rd_addr[AW +: AW] = 9;
        tick();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'hA5A5A5A5 || rd_data[WIDTH +: WIDTH] !== 32'h0000009A || rd_valid !== 2'b11) begin
            mismatched++;
            $display("FAIL b2b_second: p0 %h p1 %h valid %b want a5a5a5a5 0000009a 11",
                     rd_data[0 +: WIDTH], rd_data[WIDTH +: WIDTH], rd_valid);
        end
        rd_en = 2'b01; rd_addr[0 +: AW] = 9;
        tick();
        idle();
        compared++;
        if (rd_data[0 +: WIDTH] !== 32'h0000009A || rd_valid !== 2'b01 || rd_data[WIDTH +: WIDTH] !== 32'h0000009A) begin
            mismatched++;
            $display("FAIL b2b_third: p0 %h valid %b p1 %h want 0000009a 01 0000009a",
                     rd_data[0 +: WIDTH], rd_valid, rd_data[WIDTH +: WIDTH]);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        idle();
        tick();
        tick();
        compared++;
        if (rd_data !== '0 || rd_valid !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
            mismatched++;
            $display("FAIL init_reset: data %h valid %b busy %b vec %h want all 0", rd_data, rd_valid, rd_busy, busy_vec);
        end
        rst = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_out_of_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the myriscv core; successor to the single-port register array.
- Provides NREAD independently addressed registered read ports and one write port.
- Register 0 is hardwired to zero.
- An integrated pending-write scoreboard lets decode see operands that are not yet written back.
- Sits between decode (read/issue) and writeback (write).

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of architectural registers; 2..1024, need not be a power of two
NREAD, 2, number of read ports; 1..4
AW, $clog2(DEPTH), derived localparam; address width; not overridable

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low; clears all state
rd_en  input  NREAD  per-port read request
rd_addr  input  NREAD*AW  read addresses; port p uses bits [p*AW +: AW]
rd_data  output  NREAD*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH]
rd_valid  output  NREAD  high the cycle after an accepted rd_en
rd_busy  output  NREAD  registered: operand was pending at sample time
wr_en  input  1  write enable
wr_addr  input  AW  write address
wr_data  input  WIDTH  write data
sb_set_en  input  1  issue of an instruction that will write sb_set_addr
sb_set_addr  input  AW  destination marked pending
busy_vec  output  DEPTH  current scoreboard state; bit 0 is always 0

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately, including mid-operation):
  - all registers, rd_data, rd_valid, rd_busy and busy_vec go to 0.
  - The first edge after rst rises behaves as a normal cycle.
- Write: at a rising edge with wr_en=1, wr_addr!=0 and wr_addr<DEPTH, reg[wr_addr] <= wr_data.
  - Writes to address 0 are dropped.
  - Writes to addresses >=DEPTH are dropped.
- Read, per port p (1-cycle latency):
  - rd_en[p]=1 at edge N -> rd_data[p] and rd_valid[p]=1 after edge N.
  - rd_en[p]=0 -> rd_valid[p]=0; rd_data[p] and rd_busy[p] hold their previous values.
  - Address 0 or address >=DEPTH returns data 0 and busy 0.
  - All ports are independent. Identical addresses on several ports return identical data.
- Scoreboard:
  - One busy bit per register.
  - sb_set_en sets busy[sb_set_addr]; wr_en clears busy[wr_addr].
  - Same-edge set and clear of the same address: set wins (a new producer was issued).
  - busy[0] is never set; sets of addresses >=DEPTH are ignored.
  - Default rd_busy[p] = busy[rd_addr[p]] as it was before the edge.
- Same-edge read and write to the same nonzero address: result depends on REGFILE_BYPASS_EN (see below).
- No internal FSM beyond per-port valid registers; no backpressure; every request is accepted.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - A read whose address matches a same-edge valid write returns wr_data.
  - Its rd_busy is 0, unless sb_set_en targets the same address on that edge.
- Undefined: the read returns the old register value.
  - rd_busy reflects the pre-edge busy bit, so a consumer sees busy=1 and re-reads.
- The register and scoreboard contents after the edge are identical in both configurations.

Decomposition:
- Shared package regfile_pkg holds:
  - ZERO_REG constant (0);
  - default WIDTH/DEPTH/NREAD constants;
  - addr_valid function (addr!=0 && addr<DEPTH).
- One sub-module: regfile_scoreboard (DEPTH busy bits, set/clear logic, busy_vec). Instantiated once.
- Read ports are built with a generate loop over NREAD.

Test Plan:
- Reset: pulse rst low mid-stream after writing reg5=0xDEADBEEF and setting busy[5].
  - Required: rd_data, rd_valid and busy_vec read 0 immediately.
  - Required: a read of reg5 after reset returns 0.
- Basic: write reg3=0x12345678; next cycle read port0 addr3 and port1 addr3.
  - Required: both ports return 0x12345678 with rd_valid=1 one cycle later.
  - Required: rd_valid=0 on the following idle cycle.
- Zero register: write reg0=0xFFFFFFFF and set sb on addr0.
  - Required: a read of addr0 returns 0 with rd_busy=0; busy_vec[0]=0.
- Collision: write reg7=0xA5A5A5A5 while port0 reads addr7 (reg7 previously 0x1).
  - Required with REGFILE_BYPASS_EN: 0xA5A5A5A5, busy 0.
  - Required without: 0x1, and busy as previously set.
- Scoreboard: sb_set addr9 -> busy_vec[9]=1.
  - Required: a read of addr9 returns rd_busy=1.
  - Required: on an edge with a write to 9 plus sb_set 9, busy_vec[9] stays 1.
  - Required: a later write alone clears it.
- Non-power-of-two: DEPTH=20, write addr 25.
  - Required: no state changes; a read of addr 25 returns 0.
